// File: rtl/xboot_loader_pkg.sv
// xboot_loader_pkg: shared instruction width default and loader state encoding.
package xboot_loader_pkg;
   localparam int XBOOT_INSTR_W = 32;
   typedef enum logic [2:0] {XBOOT_HDR, XBOOT_LOAD, XBOOT_CHK, XBOOT_DONE, XBOOT_ERR} xboot_state_t;
endpackage

// File: rtl/xboot_packer.sv
// xboot_packer: MSB-first byte-to-word shift register with per-word byte count;
// word_valid/word_data appear one cycle after the last byte of a word.
module xboot_packer import xboot_loader_pkg::*; #(
   parameter int INSTR_W = XBOOT_INSTR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_en,
   input  logic               i_keep,
   input  logic [7:0]         i_data,
   output logic               o_last,
   output logic               o_word_valid,
   output logic [INSTR_W-1:0] o_word_data
);
   localparam int BPW = INSTR_W / 8;
   localparam int CW = BPW > 1 ? $clog2(BPW) : 1;
   logic [CW-1:0]      r_cnt;
   logic [INSTR_W-1:0] r_sh;
   logic [INSTR_W-1:0] w_word;
   assign w_word = (r_sh << 8) | INSTR_W'(i_data);
   assign o_last = i_en && r_cnt == CW'(BPW - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_cnt        <= '0;
         r_sh         <= '0;
         o_word_valid <= 1'b0;
         o_word_data  <= '0;
      end else begin
         o_word_valid <= o_last && i_keep;
         if (i_en) begin
            r_cnt <= o_last ? '0 : r_cnt + 1'b1;
            r_sh  <= w_word;
         end
         if (o_last && i_keep)
            o_word_data <= w_word;
      end
endmodule

// File: rtl/xboot_loader.sv
// xboot_loader: streams a length-prefixed byte image into instruction memory and
// holds the controller in reset until done; XBOOT_CHKSUM_EN adds a trailing XOR byte.
module xboot_loader import xboot_loader_pkg::*; #(
   parameter int INSTR_W     = XBOOT_INSTR_W,
   parameter int IMEM_ADDR_W = 10,
   parameter int LEN_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic                   imem_we,
   output logic [IMEM_ADDR_W-1:0] imem_addr,
   output logic [INSTR_W-1:0]     imem_wdata,
   output logic                   ctrl_rst,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);
   localparam int HB = LEN_W / 8;
   localparam logic [LEN_W:0] DEPTH = (LEN_W + 1)'(2 ** IMEM_ADDR_W);
`ifdef XBOOT_CHKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif
   xboot_state_t     r_state, w_next;
   logic [7:0]       r_hcnt, r_xor;
   logic [LEN_W-1:0] r_n, r_idx, w_n_shift;
   logic             r_ovf, w_acc, w_load, w_last, w_in_range, w_ovf_next;
   assign w_acc      = s_valid && s_ready;
   assign w_load     = w_acc && r_state == XBOOT_LOAD;
   assign w_n_shift  = (r_n << 8) | LEN_W'(s_data);
   assign w_in_range = {1'b0, r_idx} < DEPTH;
   assign w_ovf_next = r_ovf || !w_in_range;
   always_comb begin
      w_next = r_state;
      if (w_acc && r_state == XBOOT_HDR && r_hcnt == 8'(HB - 1))
         w_next = w_n_shift == '0 ? (CHK_EN ? XBOOT_CHK : XBOOT_DONE) : XBOOT_LOAD;
      if (w_last && r_idx == r_n - 1'b1)
         w_next = CHK_EN ? XBOOT_CHK : (w_ovf_next ? XBOOT_ERR : XBOOT_DONE);
      if (w_acc && r_state == XBOOT_CHK)
         w_next = s_data == r_xor && !r_ovf ? XBOOT_DONE : XBOOT_ERR;
   end
   // Out-of-range words are still packed but never strobed, so addresses never wrap.
   xboot_packer #(.INSTR_W(INSTR_W)) u_packer (
      .clk          (clk),
      .rst          (rst),
      .i_en         (w_load),
      .i_keep       (w_in_range),
      .i_data       (s_data),
      .o_last       (w_last),
      .o_word_valid (imem_we),
      .o_word_data  (imem_wdata)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state   <= XBOOT_HDR;
         r_hcnt    <= '0;
         r_n       <= '0;
         r_idx     <= '0;
         r_xor     <= '0;
         r_ovf     <= 1'b0;
         s_ready   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         ctrl_rst  <= 1'b1;
         imem_addr <= '0;
      end else begin
         r_state  <= w_next;
         s_ready  <= w_next == XBOOT_HDR || w_next == XBOOT_LOAD || w_next == XBOOT_CHK;
         busy     <= w_next == XBOOT_HDR || w_next == XBOOT_LOAD || w_next == XBOOT_CHK;
         done     <= w_next == XBOOT_DONE;
         err      <= w_next == XBOOT_ERR;
         ctrl_rst <= r_state != XBOOT_DONE;
         if (w_acc && r_state == XBOOT_HDR) begin
            r_n    <= w_n_shift;
            r_hcnt <= r_hcnt + 1'b1;
         end
         if (w_load)
            r_xor <= r_xor ^ s_data;
         if (w_last) begin
            r_idx <= r_idx + 1'b1;
            r_ovf <= w_ovf_next;
            if (w_in_range)
               imem_addr <= r_idx[IMEM_ADDR_W-1:0];
         end
      end
endmodule

// File: tb/tb_xboot_loader.sv
// tb_xboot_loader: directed and randomized image loads checked against a
// word-list model of the expected memory writes and final status.
module tb_xboot_loader;
   localparam int AW = 2;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] s_data = '0;
   logic s_valid = 1'b0;
   logic s_ready, imem_we, ctrl_rst, busy, done, err;
   logic [AW-1:0] imem_addr;
   logic [31:0] imem_wdata;
   int errors = 0, checks = 0, cyc = 0, w_cnt = 0, stalls = 0;
   int done_cyc = -1, rel_cyc = -1, last_we_cyc = -1;
   logic [AW-1:0] wa [1024];
   logic [31:0] wd [1024];
   logic pdone = 1'b0, pcr = 1'b1;
   logic [31:0] img [$];
   always #5 clk = ~clk;
   xboot_loader #(.INSTR_W(32), .IMEM_ADDR_W(AW), .LEN_W(16)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .ctrl_rst(ctrl_rst), .busy(busy), .done(done), .err(err)
   );
   always @(negedge clk) begin
      cyc++;
      if (imem_we && w_cnt < 1024) begin
         wa[w_cnt] = imem_addr;
         wd[w_cnt] = imem_wdata;
         w_cnt++;
         last_we_cyc = cyc;
      end
      if (done && !pdone) done_cyc = cyc;
      if (!ctrl_rst && pcr) rel_cyc = cyc;
      pdone = done;
      pcr = ctrl_rst;
   end
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic reset_vals();
      check("rst_s_ready", s_ready, 0);
      check("rst_imem_we", imem_we, 0);
      check("rst_imem_addr", imem_addr, 0);
      check("rst_imem_wdata", imem_wdata, 0);
      check("rst_ctrl_rst", ctrl_rst, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
   endtask
   task automatic do_reset();
      rst = 1'b1;
      s_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic send(input logic [7:0] b, input bit gaps);
      bit acc = 1'b0;
      for (int g = 0; g < 4 && gaps && $urandom_range(0, 1) == 1; g++) begin
         s_valid = 1'b0;
         s_data = 8'($urandom);
         @(posedge clk);
         #1;
      end
      s_data = b;
      s_valid = 1'b1;
      for (int k = 0; k < 50 && !acc; k++) begin
         acc = s_ready;
         if (!acc) stalls++;
         @(posedge clk);
         #1;
      end
      check("accept", acc, 1);
   endtask
   task automatic load(input bit gaps, input logic [7:0] chk_adj);
      int n, base, nexp;
      logic [7:0] xs;
      bit exp_err;
      n = img.size();
      xs = '0;
      do_reset();
      base = w_cnt;
      send(8'(n >> 8), gaps);
      stalls = 0;
      send(8'(n), gaps);
      foreach (img[i])
         for (int j = 3; j >= 0; j--) begin
            send(img[i][8*j +: 8], gaps);
            xs ^= img[i][8*j +: 8];
         end
`ifdef XBOOT_CHKSUM_EN
      send(xs ^ chk_adj, gaps);
      exp_err = n > DEPTH || chk_adj != 0;
`else
      exp_err = n > DEPTH || chk_adj != 0;
`endif
      s_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      nexp = n > DEPTH ? DEPTH : n;
      check("nwrites", w_cnt - base, nexp);
      for (int i = 0; i < nexp && base + i < w_cnt; i++) begin
         check("waddr", wa[base + i], i);
         check("wdata", wd[base + i], img[i]);
      end
      check("done", done, !exp_err);
      check("err", err, exp_err);
      check("ctrl_rst", ctrl_rst, exp_err);
      check("busy_end", busy, 0);
      check("s_ready_end", s_ready, 0);
      if (!gaps) check("stalls", stalls, 0);
      if (!exp_err) begin
         check("release_lag", rel_cyc - done_cyc, 1);
         if (nexp > 0) check("we_before_release", last_we_cyc < rel_cyc, 1);
      end
   endtask
   initial begin
      @(negedge clk);
      reset_vals();
      img = '{32'h11223344, 32'hAABBCCDD};
      load(1'b0, 8'h00);
      load(1'b1, 8'h00);
      img.delete();
      load(1'b0, 8'h00);
`ifdef XBOOT_CHKSUM_EN
      load(1'b0, 8'h01);
      img = '{32'h01020408};
      load(1'b0, 8'h00);
      load(1'b0, 8'h01);
`endif
      img.delete();
      for (int i = 0; i < 5; i++) img.push_back($urandom);
      load(1'b0, 8'h00);
      for (int t = 0; t < 6; t++) begin
         img.delete();
         for (int i = 0; i < int'($urandom_range(1, 6)); i++) img.push_back($urandom);
         load(1'($urandom_range(0, 1)), 8'h00);
      end
      do_reset();
      send(8'h00, 1'b0);
      send(8'h02, 1'b0);
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      rst = 1'b1;
      #1;
      reset_vals();
      @(negedge clk);
      rst = 1'b0;
      img = '{32'hDEADBEEF, 32'h0BADF00D};
      load(1'b0, 8'h00);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
